// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and byte stream bundle for ram_stream_reader.
// Carries o_last only when RAM_READER_LAST_EN is defined.
interface ram_stream_reader_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [ADDR_W:0]   i_len;
  logic [ADDR_W-1:0] o_raddr;
  logic [DATA_W-1:0] i_rdata;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
`ifdef RAM_READER_LAST_EN
  logic              o_last;
`endif
  logic              o_busy;
  logic              o_done;

`ifdef RAM_READER_LAST_EN
  modport master (
    input  i_start, i_base, i_len, i_rdata, i_ready,
    output o_raddr, o_valid, o_data, o_last, o_busy, o_done
  );
  modport slave (
    output i_start, i_base, i_len, i_rdata, i_ready,
    input  o_raddr, o_valid, o_data, o_last, o_busy, o_done
  );
`else
  modport master (
    input  i_start, i_base, i_len, i_rdata, i_ready,
    output o_raddr, o_valid, o_data, o_busy, o_done
  );
  modport slave (
    output i_start, i_base, i_len, i_rdata, i_ready,
    input  o_raddr, o_valid, o_data, o_busy, o_done
  );
`endif
endinterface

// File: rtl/ram_stream_reader.sv
// Streams a byte range out of a registered-read RAM through a 2-entry skid buffer.
// Optional o_last marker is built only when RAM_READER_LAST_EN is defined.
module ram_stream_reader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  ram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LenOne  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W:0]   rem_q;
  logic              issued_q;  // o_raddr holds a fresh address this cycle
  logic              arrive_q;  // i_rdata holds a requested byte this cycle
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
`ifdef RAM_READER_LAST_EN
  logic [ADDR_W:0]   left_q;
`endif

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              hs;
  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        pending;

  always_comb begin
    valid = (occ_q != 2'd0) || arrive_q;
    // An arriving byte is presented directly when the buffer is empty.
    if (occ_q != 2'd0) begin
      data = fifo_q[rd_ptr_q];
    end else if (arrive_q) begin
      data = bus.i_rdata;
    end else begin
      data = '0;
    end
    hs      = valid && bus.i_ready;
    pop     = hs && (occ_q != 2'd0);
    push    = arrive_q && ((occ_q != 2'd0) || !hs);
    occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
    pending = {1'b0, occ_q} + {2'b0, arrive_q} + {2'b0, issued_q};
    issue   = (state_q == StRun) && (rem_q != '0) && (pending < (3'd2 + {2'b0, hs}));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      raddr_q   <= '0;
      rem_q     <= '0;
      issued_q  <= 1'b0;
      arrive_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
`ifdef RAM_READER_LAST_EN
      left_q    <= '0;
`endif
    end else begin
      arrive_q <= issued_q;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
      occ_q    <= occ_d;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.i_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
`ifdef RAM_READER_LAST_EN
      if (hs) begin
        left_q <= left_q - LenOne;
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            if (bus.i_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              // First read goes out with the command itself.
              raddr_q  <= bus.i_base;
              addr_q   <= bus.i_base + AddrOne;
              rem_q    <= bus.i_len - LenOne;
              issued_q <= 1'b1;
              busy_q   <= 1'b1;
              state_q  <= (bus.i_len == LenOne) ? StDrain : StRun;
`ifdef RAM_READER_LAST_EN
              left_q   <= bus.i_len;
`endif
            end
          end
        end
        StRun: begin
          if (issue) begin
            raddr_q  <= addr_q;
            addr_q   <= addr_q + AddrOne;
            rem_q    <= rem_q - LenOne;
            issued_q <= 1'b1;
            if (rem_q == LenOne) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((occ_d == 2'd0) && !issued_q) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_raddr = raddr_q;
  assign bus.o_valid = valid;
  assign bus.o_data  = data;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;
`ifdef RAM_READER_LAST_EN
  assign bus.o_last  = valid && (left_q == LenOne);
`endif

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side streaming engine for the 1024-byte dual-port data RAM. Accepts a command (base address, byte count), drives the RAM read port, absorbs the RAM's one-cycle registered read latency with a 2-entry skid buffer, and delivers the bytes in address order on a valid/ready byte stream. Typical consumers are the UART TX path and DMA-style copy logic; the RAM's write port stays with the producer.

## Interface
- `ADDR_W`, default 10: RAM address width; the RAM holds 2^ADDR_W bytes.
- `DATA_W`, default 8: RAM word and stream data width.

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `i_start` input 1: command strobe; sampled only in IDLE.
- `i_base` input ADDR_W: first byte address.
- `i_len` input ADDR_W+1: byte count, 0..2^ADDR_W.
- `o_raddr` output ADDR_W: RAM read address, registered.
- `i_rdata` input DATA_W: RAM read data; valid one cycle after `o_raddr` is sampled.
- `o_valid` output 1: stream byte valid.
- `o_data` output DATA_W: stream byte.
- `i_ready` input 1: consumer accepts the byte; a handshake occurs when `o_valid` and `i_ready` are both high.
- `o_last` output 1: marks the final byte. Present only with `RAM_READER_LAST_EN`.
- `o_busy` output 1: a command is in progress.
- `o_done` output 1: one-cycle pulse when a command completes.

## Operation
**States**
- IDLE: waiting for a command.
- RUN: reads still to be issued.
- DRAIN: all reads issued; buffer and in-flight read not yet empty.
- DONE: one-cycle completion state; returns to IDLE.

**Transitions**
- IDLE with `i_start`=1 and `i_len`>0 → RUN. Latch the remaining count = `i_len` and the address = `i_base`.
- IDLE with `i_start`=1 and `i_len`=0 → DONE. No read is issued and no byte is emitted.
- `i_start` is ignored in RUN, DRAIN and DONE. No queuing.

**Read issue**
- A read is issued in a cycle when remaining > 0 and (occupancy + in-flight − handshake_this_cycle) < 2.
- Issuing a read sets `o_raddr` to the current address, increments the address modulo 2^ADDR_W (1023 wraps to 0), and decrements remaining.
- Returned data is written to the skid buffer. The buffer never overflows and never drops a byte.
- When the last read is issued: RUN → DRAIN. When the buffer is empty and nothing is in flight: DRAIN → DONE.

**Stream**
- `o_data` is always the head of the buffer. `o_valid` = buffer not empty.
- `o_valid`/`o_data` hold stable while `i_ready`=0.
- Bytes are emitted strictly in address order, each exactly once.

**Status**
- `o_busy`=1 in RUN and DRAIN, and 0 in IDLE and DONE.
- `o_done`=1 only in DONE.

## Timing
- Reset values: `o_raddr`=0, `o_valid`=0, `o_data`=0, `o_last`=0, `o_busy`=0, `o_done`=0; state = IDLE; buffer empty.
- `i_start` sampled high in cycle 0 → `o_raddr`=base and `o_busy`=1 in cycle 1 → `o_valid`=1 with `o_data`=mem[base] in cycle 2.
- With `i_ready` held high, one byte per cycle with no bubbles. An N-byte command gives its final handshake in cycle N+1 and `o_done` in cycle N+2.
- `i_ready` deasserted for any number of cycles: at most 2 bytes are buffered, no additional reads are issued, and the stream resumes with the next byte in the cycle `i_ready` returns high.
- A new command may be accepted in the cycle after `o_done` (IDLE).
- `rst` asserted mid-command: all outputs go to their reset values immediately, the command is aborted, and buffered bytes are discarded.

## Configuration
- `RAM_READER_LAST_EN` defined: `o_last` exists. It is 1 exactly while the final byte of a command is at the buffer head with `o_valid`=1, and 0 otherwise (including `i_len`=0).
- `RAM_READER_LAST_EN` undefined: the `o_last` port and its logic are absent. All other behaviour is identical.

## Test plan
- mem[0x010..0x013]=A0..A3, base=0x010, len=4, `i_ready`=1 → bytes A0,A1,A2,A3 in cycles 2–5; `o_done` in cycle 6; `o_last` only with A3.
- base=0x3FE, len=4 → reads 0x3FE, 0x3FF, 0x000, 0x001 in that order; bytes mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001].
- len=16 with random `i_ready` (50% duty) → all 16 bytes in order, no duplicates or losses; `o_data` stable while stalled; never more than 2 reads outstanding.
- len=0 → `o_done` in cycle 1; `o_valid` never asserts; `o_busy` stays 0.
- `i_start` pulsed during RUN with a different base → ignored; the original stream completes unchanged.
- `rst` pulsed mid-stream (after 3 of 10 bytes) → all outputs 0 at once; a fresh len=2 command afterwards streams correctly.
